// File: rtl/csel_block.sv
`default_nettype none
// ============================================================================
// Module      : csel_block
// Description : Combinational carry-select slice; two speculative sums
//               selected by the incoming carry.
// Revision    : 1.0 - initial release
// ============================================================================
module csel_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           c_msb
);

    logic [BLK:0] w_sum0;
    logic [BLK:0] w_sum1;

    assign w_sum0 = {1'b0, x} + {1'b0, y};
    assign w_sum1 = {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, 1'b1};

    assign {cout, s} = cin ? w_sum1 : w_sum0;

    // Each sum bit is x ^ y ^ carry-in, so the carry into the top bit is recoverable.
    assign c_msb = s[BLK-1] ^ x[BLK-1] ^ y[BLK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_csel_adder
// Description : Pipelined carry-select adder/subtractor, one slice resolved
//               per stage, with valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int c_nblk = WIDTH / BLK;

    if ((WIDTH % BLK) != 0 || WIDTH < BLK) begin : g_width_check
        $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLK");
    end

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             w_en;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_c_msb;
    logic             r_v_out;

    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub | c_in;
    // Single enable: the whole pipe moves or holds as one, bubbles included.
    assign w_en    = ~r_v_out | out_ready;

    for (genvar k = 0; k < c_nblk; k++) begin : g_stage
        localparam int c_lo = k * BLK;

        logic [WIDTH-1:0]      w_acc_in;
        logic [WIDTH-1:c_lo]   w_b_in;
        logic                  w_cin;
        logic                  w_v_in;
        logic [BLK-1:0]        w_s;
        logic                  w_cout;
        logic                  w_c_msb;
        logic [WIDTH-1:0]      w_res;

        // Accumulator carries resolved result bits below the slice and raw operand A above it.
        if (k == 0) begin : g_front
            assign w_acc_in = a;
            assign w_b_in   = w_b_eff;
            assign w_cin    = w_c0;
            assign w_v_in   = in_valid;
        end else begin : g_chain
            assign w_acc_in = g_stage[k-1].g_reg.r_acc;
            assign w_b_in   = g_stage[k-1].g_reg.r_b;
            assign w_cin    = g_stage[k-1].g_reg.r_c;
            assign w_v_in   = g_stage[k-1].g_reg.r_v;
        end

        csel_block #(
            .BLK (BLK)
        ) u_blk (
            .x     (w_acc_in[c_lo +: BLK]),
            .y     (w_b_in[c_lo +: BLK]),
            .cin   (w_cin),
            .s     (w_s),
            .cout  (w_cout),
            .c_msb (w_c_msb)
        );

        always_comb begin
            w_res                 = w_acc_in;
            w_res[c_lo +: BLK]    = w_s;
        end

        if (k < c_nblk - 1) begin : g_reg
            logic [WIDTH-1:0]        r_acc;
            logic [WIDTH-1:c_lo+BLK] r_b;
            logic                    r_c;
            logic                    r_v;
            // Carry into a slice MSB only matters for the top slice.
            logic                    w_unused_c_msb;

            assign w_unused_c_msb = w_c_msb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                    r_b   <= '0;
                    r_c   <= 1'b0;
                    r_v   <= 1'b0;
                end else if (w_en) begin
                    r_acc <= w_res;
                    r_b   <= w_b_in[WIDTH-1:c_lo+BLK];
                    r_c   <= w_cout;
                    r_v   <= w_v_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_c_msb <= 1'b0;
            r_v_out <= 1'b0;
        end else if (w_en) begin
            r_s     <= g_stage[c_nblk-1].w_res;
            r_c_out <= g_stage[c_nblk-1].w_cout;
            r_c_msb <= g_stage[c_nblk-1].w_c_msb;
            r_v_out <= g_stage[c_nblk-1].w_v_in;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_v_out;
    assign s         = r_s;
    assign c_out     = r_c_out;
    assign ovf       = r_c_msb ^ r_c_out;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_csel_adder
// Description : Scoreboard bench: 16/4 directed + burst + reset cases, and
//               an exhaustive 8/2 sweep split over four instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_csel_adder;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_out    = 0;
    bit lat_mode = 1'b1;
    bit sweep_go = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_csel_adder #(.WIDTH(W), .BLK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .ovf(ovf)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {ovf, c_out, s[15:0]} for a w-bit operation.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] mask;
        logic [15:0] ye;
        logic [16:0] full;
        logic [15:0] ss;
        logic        am, bm, sm;
        mask = 16'((32'd1 << w) - 32'd1);
        ye   = (sb ? ~y : y) & mask;
        full = {1'b0, x & mask} + {1'b0, ye} + {16'd0, (sb ? 1'b1 : ci)};
        ss   = full[15:0] & mask;
        am   = x[w-1];
        bm   = ye[w-1];
        sm   = ss[w-1];
        return {((am == bm) && (sm != am)), full[w], ss};
    endfunction

    typedef struct {
        logic [17:0] exp;
        int          cyc;
        bit          lat;
    } sb_t;

    sb_t sb_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                sb_q.push_back('{model(W, a, b, c_in, sub), cyc, lat_mode});
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_value("spurious_out_valid", out_valid, 0);
                end else begin
                    check_value("result", {ovf, c_out, s}, sb_q[0].exp);
                    if (out_ready) begin
                        if (sb_q[0].lat) check_value("latency", cyc - sb_q[0].cyc, LAT);
                        void'(sb_q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
        int t;
        a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_value("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check_value(tag, sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Exhaustive 8-bit sweep: one instance per {sub, c_in} combination.
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam logic CI = (g % 2) == 1;
        localparam logic SB = g >= 2;

        logic        iv, ir, ov, co, of;
        logic [7:0]  xa, xb, xs;
        logic [17:0] q[$];
        int          nout = 0;
        int          nacc = 0;
        bit          done = 1'b0;

        pipelined_csel_adder #(.WIDTH(8), .BLK(2)) u_dut8 (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .c_in(CI), .sub(SB),
            .out_valid(ov), .out_ready(1'b1),
            .s(xs), .c_out(co), .ovf(of)
        );

        always @(negedge clk) begin
            if (!rst) begin
                if (iv && ir) begin
                    q.push_back(model(8, {8'h00, xa}, {8'h00, xb}, CI, SB));
                    nacc++;
                end
                if (ov) begin
                    if (q.size() == 0) begin
                        check_value("sweep_spurious", ov, 0);
                    end else begin
                        check_value("sweep_result", {of, co, 8'h00, xs}, q[0]);
                        void'(q.pop_front());
                        nout++;
                    end
                end
            end
        end

        initial begin
            int t;
            iv = 1'b0; xa = '0; xb = '0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int i = 0; i < 65536; i++) begin
                xa = i[15:8];
                xb = i[7:0];
                iv = 1'b1;
                @(posedge clk);
                #1;
            end
            iv = 1'b0;
            t = 0;
            while (q.size() != 0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            check_value("sweep_accepted", nacc, 65536);
            check_value("sweep_count", nout, 65536);
            done = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int t;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_s", s, 0);
        check_value("rst_c_out", c_out, 0);
        check_value("rst_ovf", ovf, 0);
        check_value("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed add/subtract vectors with latency checks.
        lat_mode = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        drain("directed_drain");

        // Burst of 8, then a 5-cycle stall with a rejected offer pending.
        lat_mode = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 8; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        out_ready = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_value("stall_in_ready", in_ready, 0);
            check_value("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("burst_drain");
        check_value("burst_count", n_out - n0, 8);

        // Reset with three operations in flight.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        send(16'h5555, 16'h6666, 1'b0, 1'b1);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_value("post_rst_out_valid", out_valid, 0);
        check_value("post_rst_in_ready", in_ready, 1);
        check_value("post_rst_s", s, 0);
        out_ready = 1'b1;
        n0 = n_out;
        repeat (6) @(negedge clk);
        check_value("post_rst_no_output", n_out - n0, 0);
        @(posedge clk);
        #1;
        lat_mode = 1'b1;
        send(16'hABCD, 16'h1234, 1'b1, 1'b0);
        drain("post_rst_drain");
        check_value("post_rst_count", n_out - n0, 1);

        sweep_go = 1'b1;
        t = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done) && t < 70000) begin
            @(negedge clk);
            t++;
        end
        check_value("sweep_done", {g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
